pipe_skid_reg: RTL and testbench

Parametrised elastic pipeline register for the pipeline stage boundaries (IF/ID first, then ID/EX and beyond). It carries an instruction word and PC between stages under a valid/ready handshake. An optional two-entry skid buffer decouples upstream ready from downstream stall timing. It supports flush, drives a NOP bubble when empty, and provides saturating stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 6 +
 rtl/pipe_skid_reg_sat_counter.sv | 14 +
 rtl/pipe_skid_reg.sv | 113 +++++++++++
 tb/tb_pipe_skid_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and state encoding for the elastic pipeline register.
package pipe_pkg;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with optional two-entry skid buffer,
// flush, NOP bubble when empty and saturating stall/flush counters.
module pipe_skid_reg import pipe_pkg::*; #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
  parameter bit                SKID_EN  = 1'b1,
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ins,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ins,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_ins_q, main_ins_d, skid_ins_q, skid_ins_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic              in_fire, out_fire;
  assign out_valid = state_q != EMPTY;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // Data registers are kept at NOP/0 whenever empty so outputs come straight from flops.
  assign out_ins   = main_ins_q;
  assign out_pc    = main_pc_q;
  always_comb begin
    state_d    = state_q;
    main_ins_d = main_ins_q;
    main_pc_d  = main_pc_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;
    if (flush) begin
      state_d    = EMPTY;
      main_ins_d = NOP_WORD;
      main_pc_d  = '0;
      skid_ins_d = NOP_WORD;
      skid_pc_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d    = ONE;
          main_ins_d = in_ins;
          main_pc_d  = in_pc;
        end
        ONE: if (in_fire && out_fire) begin
          main_ins_d = in_ins;
          main_pc_d  = in_pc;
        end else if (in_fire) begin
          state_d    = TWO;
          skid_ins_d = in_ins;
          skid_pc_d  = in_pc;
        end else if (out_fire) begin
          state_d    = EMPTY;
          main_ins_d = NOP_WORD;
          main_pc_d  = '0;
        end
        TWO: if (out_fire) begin
          state_d    = ONE;
          main_ins_d = skid_ins_q;
          main_pc_d  = skid_pc_q;
          skid_ins_d = NOP_WORD;
          skid_pc_d  = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_ins_q <= NOP_WORD;
      main_pc_q  <= '0;
      skid_ins_q <= NOP_WORD;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_ins_q <= main_ins_d;
      main_pc_q  <= main_pc_d;
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
    end
  end
  generate
    if (SKID_EN) begin : g_skid
      // Registered ready breaks the out_ready -> in_ready path; the skid absorbs the in-flight beat.
      logic in_ready_q;
      always_ff @(posedge clk) in_ready_q <= rst ? 1'b1 : (state_d != TWO);
      assign in_ready = in_ready_q;
    end else begin : g_single
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush && (state_q != EMPTY || in_fire)),
    .cnt (flush_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench for the skid (a) and single-entry (b) configurations.
module tb_pipe_skid_reg;
  localparam logic [31:0] NOP_A = 32'h0000_0013;
  localparam logic [31:0] NOP_B = 32'h0000_0000;
  typedef struct {logic [31:0] ins; logic [31:0] pc;} beat_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_ins = 0, in_pc = 0;
  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_ins, a_out_pc, b_out_ins, b_out_pc;
  logic [3:0] a_stall, a_flush, b_stall, b_flush;
  beat_t sb[$];
  int n_cmp = 0, n_err = 0;
  bit last_fire;
  always #5 clk = ~clk;
  pipe_skid_reg #(.DATA_W(32), .PC_W(32), .NOP_WORD(NOP_A), .SKID_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ins(a_out_ins), .out_pc(a_out_pc), .stall_cnt(a_stall), .flush_cnt(a_flush));
  pipe_skid_reg #(.DATA_W(32), .PC_W(32), .NOP_WORD(NOP_B), .SKID_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ins(b_out_ins), .out_pc(b_out_pc), .stall_cnt(b_stall), .flush_cnt(b_flush));
  // One clock: scoreboard the selected DUT at the falling edge, return at posedge+1.
  task automatic tick(input bit b);
    logic ov, ir;
    logic [31:0] oi, op, nop;
    beat_t e;
    @(negedge clk);
    ov  = b ? b_out_valid : a_out_valid;
    ir  = b ? b_in_ready : a_in_ready;
    oi  = b ? b_out_ins : a_out_ins;
    op  = b ? b_out_pc : a_out_pc;
    nop = b ? NOP_B : NOP_A;
    last_fire = in_valid && ir;
    if (rst) sb.delete();
    else begin
      if (ov && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out dut%0d: got ins=%h pc=%h, none expected", b, oi, op);
        end else begin
          e = sb.pop_front();
          if ({oi, op} !== {e.ins, e.pc}) begin
            n_err++;
            $display("FAIL out_beat dut%0d: got ins=%h pc=%h, need ins=%h pc=%h", b, oi, op, e.ins, e.pc);
          end
        end
      end
      if (!ov) begin
        n_cmp++;
        if ({oi, op} !== {nop, 32'h0}) begin
          n_err++;
          $display("FAIL bubble dut%0d: got ins=%h pc=%h, need ins=%h pc=0", b, oi, op, nop);
        end
      end
      if (flush) sb.delete();
      else if (last_fire) sb.push_back('{in_ins, in_pc});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v; in_ins = ins; in_pc = pc;
  endtask
  task automatic test_reset;
    rst = 1; tick(0); tick(0); rst = 0;
    n_cmp++;
    if ({a_out_valid, a_in_ready, a_out_ins, a_out_pc, a_stall, a_flush} !== {1'b0, 1'b1, NOP_A, 32'h0, 4'h0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_a: got v=%b r=%b ins=%h pc=%h st=%h fl=%h", a_out_valid, a_in_ready, a_out_ins, a_out_pc, a_stall, a_flush);
    end
    n_cmp++;
    if ({b_out_valid, b_in_ready, b_out_ins, b_out_pc} !== {1'b0, 1'b1, NOP_B, 32'h0}) begin
      n_err++;
      $display("FAIL reset_b: got v=%b r=%b ins=%h pc=%h", b_out_valid, b_in_ready, b_out_ins, b_out_pc);
    end
  endtask
  task automatic test_stream;
    out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      drive(1, i, (i - 1) * 4);
      #1;
      n_cmp++;
      if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready beat %0d: got %b need 1", i, a_in_ready); end
      tick(0);
      n_cmp++;
      if ({a_out_valid, a_out_ins} !== {1'b1, 32'(i)}) begin
        n_err++;
        $display("FAIL stream_latency beat %0d: got v=%b ins=%h need v=1 ins=%h", i, a_out_valid, a_out_ins, i);
      end
    end
    drive(0, 0, 0);
    tick(0); tick(0);
    n_cmp++;
    if (a_stall !== 4'h0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL stream_end: got stall=%h pending=%0d need 0/0", a_stall, sb.size());
    end
  endtask
  task automatic test_backpressure;
    logic [6:0] er = 7'b1100011;
    int k = 0;
    for (int c = 0; c < 8; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      drive(k < 3, 32'h10 + k, 32'h100 + 4 * k);
      #1;
      if (c < 7) begin
        n_cmp++;
        if (a_in_ready !== er[c]) begin n_err++; $display("FAIL bp_ready cyc %0d: got %b need %b", c, a_in_ready, er[c]); end
      end
      tick(0);
      if (last_fire) k++;
    end
    drive(0, 0, 0);
    n_cmp++;
    if (k != 3 || sb.size() != 0 || a_stall !== 4'h3) begin
      n_err++;
      $display("FAIL bp_end: got sent=%0d pending=%0d stall=%h need 3/0/3", k, sb.size(), a_stall);
    end
  endtask
  task automatic test_flush_two;
    out_ready = 0;
    drive(1, 32'h20, 32'h200); tick(0);
    drive(1, 32'h21, 32'h204); tick(0);
    flush = 1; drive(1, 32'h22, 32'h208); tick(0);
    flush = 0; drive(0, 0, 0);
    n_cmp++;
    if ({a_out_valid, a_in_ready, a_out_ins, a_out_pc, a_flush, a_stall} !== {1'b0, 1'b1, NOP_A, 32'h0, 4'h1, 4'h5}) begin
      n_err++;
      $display("FAIL flush_two: got v=%b r=%b ins=%h pc=%h fl=%h st=%h need 0/1/%h/0/1/5",
               a_out_valid, a_in_ready, a_out_ins, a_out_pc, a_flush, a_stall, NOP_A);
    end
    out_ready = 1; drive(1, 32'h23, 32'h20c); tick(0);
    drive(0, 0, 0); tick(0);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL flush_next: got pending=%0d need 0", sb.size()); end
  endtask
  task automatic test_flush_empty;
    flush = 1; drive(0, 0, 0); tick(0); flush = 0;
    n_cmp++;
    if (a_flush !== 4'h1 || a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_empty: got fl=%h v=%b need 1/0", a_flush, a_out_valid);
    end
    out_ready = 1; drive(1, 32'h24, 32'h210); tick(0);
    flush = 1; drive(1, 32'h25, 32'h214); tick(0);
    flush = 0; drive(0, 0, 0);
    n_cmp++;
    if (a_flush !== 4'h2 || a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_outfire: got fl=%h v=%b need 2/0", a_flush, a_out_valid);
    end
    tick(0);
  endtask
  task automatic test_reset_mid;
    out_ready = 0;
    drive(1, 32'h40, 32'h400); tick(0);
    drive(1, 32'h41, 32'h404); tick(0);
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL two_ready: got %b need 0", a_in_ready); end
    rst = 1; drive(0, 0, 0); tick(0); rst = 0;
    n_cmp++;
    if ({a_out_valid, a_in_ready, a_out_ins, a_stall, a_flush} !== {1'b0, 1'b1, NOP_A, 4'h0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b r=%b ins=%h st=%h fl=%h", a_out_valid, a_in_ready, a_out_ins, a_stall, a_flush);
    end
  endtask
  task automatic test_no_skid;
    out_ready = 1; drive(1, 32'h30, 32'h300); tick(1);
    out_ready = 0; drive(1, 32'h31, 32'h304);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL ns_ready_low cyc %0d: got %b need 0", i, b_in_ready); end
      tick(1);
      n_cmp++;
      if ({b_out_valid, b_out_ins, b_out_pc} !== {1'b1, 32'h30, 32'h300}) begin
        n_err++;
        $display("FAIL ns_hold cyc %0d: got v=%b ins=%h pc=%h need 1/30/300", i, b_out_valid, b_out_ins, b_out_pc);
      end
    end
    out_ready = 1;
    #1;
    n_cmp++;
    if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_ready_comb: got %b need 1", b_in_ready); end
    tick(1);
    n_cmp++;
    if (b_out_ins !== 32'h31) begin n_err++; $display("FAIL ns_enter: got ins=%h need 31", b_out_ins); end
    drive(0, 0, 0); tick(1);
    n_cmp++;
    if (b_stall !== 4'h2 || sb.size() != 0) begin
      n_err++;
      $display("FAIL ns_end: got stall=%h pending=%0d need 2/0", b_stall, sb.size());
    end
  endtask
  task automatic test_saturation;
    rst = 1; tick(0); rst = 0;
    out_ready = 0; drive(1, 32'h50, 32'h500); tick(0);
    drive(0, 0, 0);
    repeat (21) tick(0);
    n_cmp++;
    if (a_stall !== 4'hF) begin n_err++; $display("FAIL sat_stall: got %h need f", a_stall); end
    tick(0);
    n_cmp++;
    if (a_stall !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %h need f", a_stall); end
    flush = 1; tick(0); flush = 0;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_flush !== 4'h1) begin
      n_err++;
      $display("FAIL sat_flush: got v=%b fl=%h need 0/1", a_out_valid, a_flush);
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_two();
    test_flush_empty();
    test_reset_mid();
    test_no_skid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
